// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_DEPTH   = 128;
    localparam int DEFAULT_LATENCY = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Pipeline-to-data-memory bus: request fields from EX/MEM, completion/stall/error back.
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] data_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic [WORD_W-1:0] data_o;
    logic              ready_o;
    logic              stall_o;
    logic              err_o;

    modport master (
        output addr_i, data_i, MemRead_i, MemWrite_i,
        input  data_o, ready_o, stall_o, err_o
    );

    modport slave (
        input  addr_i, data_i, MemRead_i, MemWrite_i,
        output data_o, ready_o, stall_o, err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, cleared by the asynchronous reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Word array with reset-clear and single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder with IDLE/BUSY/DONE handshake.
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHK_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 2;

    dmem_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [IW-1:0]     addr_r;
    logic [WORD_W-1:0] wdata_r;
    logic              write_r;
    logic [WORD_W-1:0] data_r;
    logic              req_s, capture_s, commit_s, stall_s;
    logic [IW-1:0]     op_addr_s;
    logic [WORD_W-1:0] op_wdata_s;
    logic              op_write_s;
    logic              misalign_s, mem_we_s;
    logic [WORD_W-1:0] rdata_s;
    logic              unused_addr_s;

    assign req_s = bus.MemRead_i | bus.MemWrite_i;

    // Operand select: a single-cycle commit comes straight from IDLE, so it uses the live request
    always_comb begin
        if (state_r == IDLE) begin
            op_addr_s  = bus.addr_i[IW-1:0];
            op_wdata_s = bus.data_i;
            op_write_s = bus.MemWrite_i;
        end else begin
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
            op_write_s = write_r;
        end
    end

`ifdef DMEM_ALIGN_CHK_EN
    logic err_r;

    assign misalign_s = is_misaligned(op_addr_s[1:0]);

    // Error flag is high only in the DONE cycle of a misaligned access
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= commit_s & misalign_s;
        end
    end

    assign bus.err_o = err_r;
`else
    assign misalign_s = 1'b0;
    assign bus.err_o  = 1'b0;
`endif

    // Address bits above the word index wrap; byte offset only matters for alignment checking
    assign unused_addr_s = ^{bus.addr_i[WORD_W-1:IW], op_addr_s[1:0]};

    // Next-state, counter and stall decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        commit_s    = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    capture_s = 1'b1;
                    stall_s   = 1'b1;
                    if (LATENCY > 32'sd1) begin
                        state_nxt_s = BUSY;
                        cnt_nxt_s   = CNT_W'(LATENCY - 2);
                    end else begin
                        state_nxt_s = DONE;
                        commit_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = DONE;
                    commit_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, latency counter, captured request and held load data
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= {IW{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
            write_r <= 1'b0;
            data_r  <= {WORD_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (capture_s) begin
                addr_r  <= bus.addr_i[IW-1:0];
                wdata_r <= bus.data_i;
                write_r <= bus.MemWrite_i;
            end
            if (commit_s && !op_write_s && !misalign_s) begin
                data_r <= rdata_s;
            end
        end
    end

    assign mem_we_s = commit_s & op_write_s & ~misalign_s;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk_i),
        .rst_n (rst_i),
        .we    (mem_we_s),
        .addr  (op_addr_s[IW-1:2]),
        .wdata (op_wdata_s),
        .rdata (rdata_s)
    );

    assign bus.data_o  = data_r;
    assign bus.ready_o = (state_r == DONE);
    assign bus.stall_o = stall_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + short random bench for data_mem_responder with a queue-based scoreboard.
module tb_data_mem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [31:0] model_mem [128];
    logic [31:0] model_data;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH   (128),
        .LATENCY (LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.addr_i     = 32'h0;
        bus.data_i     = 32'h0;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
        model_data = 32'h0;
    endtask

    // One transaction: predict, push, drive, wait for ready, pop and compare
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        exp_t e;
        int   n;
        int   stall_n;
        logic [6:0] idx;
        logic mis;
        idx = addr[8:2];
        mis = 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        if (wr) begin
            if (!mis) model_mem[idx] = wdata;
        end else if (rd && !mis) begin
            model_data = model_mem[idx];
        end
        e.data = model_data;
        e.err  = mis;
        e.tag  = tag;
        sb_q.push_back(e);

        @(negedge clk);
        bus.addr_i     = addr;
        bus.data_i     = wdata;
        bus.MemRead_i  = rd;
        bus.MemWrite_i = wr;
        #1;
        stall_n = (bus.stall_o === 1'b1) ? 1 : 0;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) idle_inputs();
            if (bus.ready_o === 1'b1) break;
            if (bus.stall_o === 1'b1) stall_n++;
        end
        check({tag, " ready"}, bus.ready_o, 1'b1);
        check({tag, " latency"}, n, LAT);
        check({tag, " stall cycles"}, stall_n, LAT);
        check({tag, " stall at ready"}, bus.stall_o, 1'b0);
        e = sb_q.pop_front();
        check({e.tag, " data_o"}, bus.data_o, e.data);
        check({e.tag, " err_o"}, bus.err_o, e.err);
        @(posedge clk);
        #1;
        check({tag, " ready drop"}, bus.ready_o, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        checks = 0;
        errors = 0;
        clear_model();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready_o", bus.ready_o, 1'b0);
        check("reset stall_o", bus.stall_o, 1'b0);
        check("reset data_o", bus.data_o, 32'h0);
        check("reset err_o", bus.err_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, "read cleared 0x10");
        do_op(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "write 0x10");
        do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, "read 0x10");
        do_op(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, "write holds data_o");
        do_op(1'b0, 1'b1, 32'h0000_0200, 32'h0000_0055, "write wrap 0x200");
        do_op(1'b1, 1'b0, 32'h0000_0000, 32'h0, "read word0 wrap");
        do_op(1'b1, 1'b1, 32'h0000_0008, 32'h0000_1234, "both high 0x8");
        do_op(1'b1, 1'b0, 32'h0000_0008, 32'h0, "read 0x8");
        do_op(1'b1, 1'b0, 32'h0000_0020, 32'h0, "read 0x20");

        // Reset while a write to 0x4 is in BUSY
        @(negedge clk);
        bus.addr_i     = 32'h0000_0004;
        bus.data_i     = 32'hCAFE_F00D;
        bus.MemWrite_i = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        check("mid busy stall_o", bus.stall_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid reset stall_o", bus.stall_o, 1'b0);
        check("mid reset ready_o", bus.ready_o, 1'b0);
        check("mid reset data_o", bus.data_o, 32'h0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post reset stall_o", bus.stall_o, 1'b0);
        do_op(1'b1, 1'b0, 32'h0000_0004, 32'h0, "read 0x4 after abort");
        do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, "read 0x10 after reset");

        do_op(1'b1, 1'b0, 32'h0000_0008, 32'h0, "preload data_o");
        do_op(1'b0, 1'b1, 32'h0000_0006, 32'hA5A5_A5A5, "misaligned write 0x6");
        do_op(1'b1, 1'b0, 32'h0000_0004, 32'h0, "read word1");

        for (int k = 0; k < 16; k++) begin
            a  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 9);
            op = $urandom_range(0, 2);
            do_op((op != 1), (op != 0), a, $urandom, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
